gate_sprite_renderer: RTL and testbench

Upstream pixel-fetch stage for the gate palette lookup. For every pixel coordinate from the VGA controller, it:
- decides whether the pixel lies inside a gate sprite placed at a frame-latched screen position;
- generates the sprite ROM address, with optional power-of-two upscaling;
- registers the 4-bit ROM data as a palette index plus a valid flag.

The palette lookup consumes `pix_index`. The colour mux uses `pix_valid` to choose between the sprite and the layer beneath it.

---
 rtl/gate_sprite_renderer.sv | 97 +++++++++
 tb/tb_gate_sprite_renderer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gate_sprite_renderer.sv
// gate_sprite_renderer
// Pixel-fetch stage in front of the gate palette lookup. Each pixel clock it
// tests the current VGA coordinate against a gate sprite whose position and
// visibility are latched once per frame, issues a registered sprite ROM
// address (with power-of-two upscaling), and registers the returned 4-bit
// texel as a palette index plus an opaque flag. Latency is 3 clk from
// DrawX/DrawY to pix_index/pix_valid, one pixel per clock.
//
// Ports:
//   clk          pixel clock
//   reset_n      asynchronous active-low reset
//   DrawX/DrawY  current pixel column/row from the VGA controller
//   blank        1 = active video
//   frame_start  one-cycle pulse that latches sprite_en/pos_x/pos_y
//   sprite_en    requested visibility
//   pos_x/pos_y  requested top-left corner
//   rom_addr     registered address to the synchronous sprite ROM
//   rom_q        ROM data, one cycle after rom_addr
//   pix_index    palette index (TRANSPARENT_IDX when no sprite)
//   pix_valid    1 = opaque sprite pixel
module gate_sprite_renderer #(
    parameter int         SPRITE_W        = 64,
    parameter int         SPRITE_H        = 32,
    parameter int         SCALE_SHIFT     = 1,
    parameter logic [3:0] TRANSPARENT_IDX = 4'h0,
    parameter int         ADDR_W          = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic              sprite_en,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        pix_index,
    output logic              pix_valid
);

    // On-screen footprint of the scaled sprite.
    localparam logic [10:0] SPAN_X = 11'(SPRITE_W << SCALE_SHIFT);
    localparam logic [10:0] SPAN_Y = 11'(SPRITE_H << SCALE_SHIFT);

    // Frame-latched copies so mid-frame upstream changes never tear the sprite.
    logic       sh_en;
    logic [9:0] sh_x, sh_y;

    // vld_pipe[0] = v1 (address issued), vld_pipe[1] = v2 (ROM data valid).
    logic [1:0] vld_pipe;

    logic [10:0]       rel_x, rel_y, tx, ty;
    logic              hit;
    logic [ADDR_W-1:0] addr_next;

    // 11-bit two's complement offsets; bit 10 set means left of / above the sprite.
    assign rel_x = {1'b0, DrawX} - {1'b0, sh_x};
    assign rel_y = {1'b0, DrawY} - {1'b0, sh_y};

    // No explicit 640/480 test: pixels past the visible edge arrive with
    // blank=0, which is what clips the sprite at the screen border.
    assign hit = sh_en & blank
               & ~rel_x[10] & (rel_x < SPAN_X)
               & ~rel_y[10] & (rel_y < SPAN_Y);

    assign tx        = rel_x >> SCALE_SHIFT;
    assign ty        = rel_y >> SCALE_SHIFT;
    assign addr_next = ADDR_W'(ty) * ADDR_W'(SPRITE_W) + ADDR_W'(tx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_en     <= 1'b0;
            sh_x      <= '0;
            sh_y      <= '0;
            rom_addr  <= '0;
            vld_pipe  <= '0;
            pix_index <= TRANSPARENT_IDX;
            pix_valid <= 1'b0;
        end else begin
            // Stage-0 in this cycle still sees the old shadow values.
            if (frame_start) begin
                sh_en <= sprite_en;
                sh_x  <= pos_x;
                sh_y  <= pos_y;
            end
            // Address holds when idle to avoid needless ROM address toggling.
            if (hit)
                rom_addr <= addr_next;
            vld_pipe  <= {vld_pipe[0], hit};
            pix_index <= vld_pipe[1] ? rom_q : TRANSPARENT_IDX;
            pix_valid <= vld_pipe[1] & (rom_q != TRANSPARENT_IDX);
        end
    end

endmodule

// File: tb/tb_gate_sprite_renderer.sv
module tb_gate_sprite_renderer;

    localparam int W = 64, H = 32, S = 1, AW = 11;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [9:0]    DrawX = '0, DrawY = '0;
    logic          blank = 1'b0, frame_start = 1'b0, sprite_en = 1'b0;
    logic [9:0]    pos_x = '0, pos_y = '0;
    logic [AW-1:0] rom_addr;
    logic [3:0]    rom_q = '0;
    logic [3:0]    pix_index;
    logic          pix_valid;

    gate_sprite_renderer #(
        .SPRITE_W(W), .SPRITE_H(H), .SCALE_SHIFT(S),
        .TRANSPARENT_IDX(4'h0), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .sprite_en(sprite_en),
        .pos_x(pos_x), .pos_y(pos_y), .rom_addr(rom_addr), .rom_q(rom_q),
        .pix_index(pix_index), .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, 1-cycle latency.
    logic [3:0] rom [0:(1<<AW)-1];
    always @(posedge clk) rom_q <= rom[rom_addr];

    typedef struct { bit v; logic [3:0] idx; } exp_t;
    exp_t q[$];

    int nvec = 0, nerr = 0;
    bit m_en = 0;
    int m_x = 0, m_y = 0;
    int exp_addr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Model state after a reset: hidden sprite, empty pipeline (two bubbles).
    task automatic model_reset();
        exp_t e;
        m_en = 0; m_x = 0; m_y = 0; exp_addr = 0;
        q.delete();
        e.v = 0; e.idx = 4'h0;
        q.push_back(e); q.push_back(e);
    endtask

    function automatic bit active(input int x, input int y);
        return (x < 640) && (y < 480);
    endfunction

    // One pixel: drive, clock, then compare against the reference model.
    task automatic step(input int x, input int y, input bit b, input bit fs);
        exp_t e, o;
        int rx, ry, a;
        bit h;
        DrawX = 10'(x); DrawY = 10'(y); blank = b; frame_start = fs;
        @(posedge clk); #1;
        rx = x - m_x; ry = y - m_y;
        h = m_en && b && rx >= 0 && rx < (W << S) && ry >= 0 && ry < (H << S);
        e.v = 0; e.idx = 4'h0;
        if (h) begin
            a = (((ry >> S) * W) + (rx >> S)) % (1 << AW);
            exp_addr = a;
            e.idx = rom[a];
            e.v = (rom[a] != 4'h0);
        end
        q.push_back(e);
        if (fs) begin
            m_en = sprite_en; m_x = int'(pos_x); m_y = int'(pos_y);
        end
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
        o = q.pop_front();
        chk("pix_valid", 32'(pix_valid), 32'(o.v));
        chk("pix_index", 32'(pix_index), 32'(o.idx));
    endtask

    task automatic rand_steps(input int n, input int x0, input int x1, input int y0, input int y1);
        for (int i = 0; i < n; i++) begin
            int x, y;
            x = int'($urandom_range(x1, x0));
            y = int'($urandom_range(y1, y0));
            step(x, y, active(x, y) && ($urandom_range(9) != 0), 1'b0);
        end
    endtask

    task automatic latch(input bit en, input int px, input int py);
        sprite_en = en; pos_x = 10'(px); pos_y = 10'(py);
        step(700, 500, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = 4'($urandom);
        rom[0] = 4'h5;  // opaque texel at the sprite origin
        rom[1] = 4'h0;  // transparent texel right next to it

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_pix_index", 32'(pix_index), 0);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        reset_n = 1'b1;
        model_reset();

        // Hidden until first frame_start
        for (int x = 100; x < 140; x++) step(x, 60, 1'b1, 1'b0);

        // Basic placement, scale 2
        latch(1'b1, 100, 50);
        step(100, 50, 1'b1, 1'b0);
        chk("origin_addr", 32'(rom_addr), 0);
        step(103, 53, 1'b1, 1'b0);
        chk("addr_65", 32'(rom_addr), 65);
        step(102, 50, 1'b1, 1'b0);   // transparent texel
        step(101, 51, 1'b1, 1'b0);   // opaque 4'h5
        repeat (3) step(700, 500, 1'b0, 1'b0);
        rand_steps(2000, 60, 260, 20, 140);

        // Mid-frame move without frame_start: sprite stays at 100
        pos_x = 10'd300;
        rand_steps(600, 60, 460, 20, 140);
        step(700, 500, 1'b0, 1'b1);
        rand_steps(600, 60, 460, 20, 140);

        // Right clip
        latch(1'b1, 600, 50);
        step(639, 50, 1'b1, 1'b0);
        chk("clip_addr", 32'(rom_addr), 19);
        step(640, 50, 1'b0, 1'b0);
        rand_steps(500, 560, 799, 20, 140);

        // Bottom clip and off-screen positions
        latch(1'b1, 300, 460);
        rand_steps(400, 260, 460, 420, 524);
        latch(1'b1, 700, 490);
        rand_steps(400, 600, 799, 440, 524);

        // Disabled sprite over a sampled full frame
        latch(1'b0, 100, 50);
        rand_steps(3000, 0, 799, 0, 524);

        // Async reset during a sprite row
        latch(1'b1, 100, 50);
        for (int x = 100; x < 130; x++) step(x, 60, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_pix_valid", 32'(pix_valid), 0);
        chk("async_pix_index", 32'(pix_index), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        for (int x = 100; x < 200; x++) step(x, 60, 1'b1, 1'b0);
        latch(1'b1, 100, 50);
        rand_steps(800, 60, 260, 20, 140);
        repeat (3) step(700, 500, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
